// File: rtl/pacman_sound_pkg.sv
// -----------------------------------------------------------------------------
// pacman_sound_pkg
// Shared constants for the Pacman sound blocks:
//   - note half-periods in system-clock cycles at the 50 MHz reference clock
//   - player state encodings
//   - default index / half-period counter widths
//   - scale_hp(): rescales a reference half-period to another clock frequency
// -----------------------------------------------------------------------------
package pacman_sound_pkg;

    // Clock frequency the note constants below are expressed against.
    localparam int unsigned REF_CLK_HZ = 50_000_000;

    // Half-periods (cycles) at REF_CLK_HZ; frequency = REF_CLK_HZ / (2 * value).
    localparam int unsigned NOTE_C5   = 47778;
    localparam int unsigned NOTE_E5   = 37922;
    localparam int unsigned NOTE_G5   = 31888;
    localparam int unsigned NOTE_A4   = 56818;
    localparam int unsigned NOTE_REST = 0;

    // Default widths.
    localparam int unsigned IDX_W_DEF = 3;
    localparam int unsigned HP_W_DEF  = 20;

    // Player state encodings.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Converts a REF_CLK_HZ half-period into cycles of clk_hz (truncating).
    // At clk_hz == REF_CLK_HZ this returns the constant unchanged.
    function automatic int unsigned scale_hp(input int unsigned hp,
                                             input int unsigned clk_hz);
        longint unsigned w_prod;
        w_prod = 64'(hp) * 64'(clk_hz);
        return 32'(w_prod / 64'(REF_CLK_HZ));
    endfunction

endpackage

// File: rtl/tone_rom.sv
// -----------------------------------------------------------------------------
// tone_rom
// Combinational melody lookup: step index -> tone half-period in clk cycles.
// Being purely combinational, a new index selects its period in the same
// cycle the index changes.
// Default melody: C5, E5, G5, REST, G5, E5, C5, REST.
//
// Ports:
//   i_idx          in   IDX_W  step index
//   o_half_period  out  HP_W   half-period in clk cycles (0 = rest)
// -----------------------------------------------------------------------------
module tone_rom
    import pacman_sound_pkg::*;
#(
    parameter int unsigned CLK_HZ = REF_CLK_HZ,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned HP_W   = HP_W_DEF
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [HP_W-1:0]  o_half_period
);

    localparam logic [HP_W-1:0] HP_C5   = HP_W'(scale_hp(NOTE_C5, CLK_HZ));
    localparam logic [HP_W-1:0] HP_E5   = HP_W'(scale_hp(NOTE_E5, CLK_HZ));
    localparam logic [HP_W-1:0] HP_G5   = HP_W'(scale_hp(NOTE_G5, CLK_HZ));
    localparam logic [HP_W-1:0] HP_REST = HP_W'(NOTE_REST);

    always_comb begin
        o_half_period = '0;
        case (i_idx)
            IDX_W'(0): o_half_period = HP_C5;
            IDX_W'(1): o_half_period = HP_E5;
            IDX_W'(2): o_half_period = HP_G5;
            IDX_W'(3): o_half_period = HP_REST;
            IDX_W'(4): o_half_period = HP_G5;
            IDX_W'(5): o_half_period = HP_E5;
            IDX_W'(6): o_half_period = HP_C5;
            IDX_W'(7): o_half_period = HP_REST;
            default:   o_half_period = HP_REST;
        endcase
    end

endmodule

// File: rtl/beat_tone_player.sv
// -----------------------------------------------------------------------------
// beat_tone_player
// Plays a fixed melody on the speaker pin. The slow toggling beat level is
// synchronised into clk and each of its edges (rising or falling) advances
// one step; inside a step a square wave at the step's note is produced.
//
// Ports:
//   clk       in   1      system clock
//   reset     in   1      asynchronous active-high reset
//   beat_in   in   1      toggling beat level; every edge is one beat
//   start     in   1      one-cycle request to play from step 0
//   stop      in   1      abort playback (highest priority)
//   speaker   out  1      square-wave speaker drive
//   busy      out  1      high while playing
//   done      out  1      one-cycle pulse on normal completion
//   note_idx  out  IDX_W  current step index
// -----------------------------------------------------------------------------
module beat_tone_player
    import pacman_sound_pkg::*;
#(
    parameter int unsigned CLK_HZ    = REF_CLK_HZ,
    parameter int unsigned NUM_NOTES = 8,
    parameter int unsigned IDX_W     = IDX_W_DEF,
    parameter int unsigned HP_W      = HP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat_in,
    input  logic             start,
    input  logic             stop,
    output logic             speaker,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] note_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_beat_tick;
    logic [1:0]       r_state;
    logic [HP_W-1:0]  r_count;
    logic             r_speaker;
    logic [IDX_W-1:0] r_note_idx;
    logic [HP_W-1:0]  w_half_period;

    tone_rom #(
        .CLK_HZ (CLK_HZ),
        .IDX_W  (IDX_W),
        .HP_W   (HP_W)
    ) u_tone_rom (
        .i_idx         (r_note_idx),
        .o_half_period (w_half_period)
    );

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= beat_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Any edge of the synced level is a beat; ticks outside PLAY are ignored,
    // which also swallows the tick seen after reset when beat_in is high.
    assign w_beat_tick = r_sync2 ^ r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_speaker  <= 1'b0;
            r_note_idx <= '0;
        end else if (stop) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_speaker  <= 1'b0;
            r_note_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_speaker <= 1'b0;
                    r_count   <= '0;
                    if (start) begin
                        r_state    <= PLAY;
                        r_note_idx <= '0;
                    end
                end
                PLAY: begin
                    if (w_beat_tick) begin
                        // Note boundary: restart the wave low on the new step.
                        r_count   <= '0;
                        r_speaker <= 1'b0;
                        if (r_note_idx == LAST_IDX) begin
                            r_state    <= DONE;
                            r_note_idx <= '0;
                        end else begin
                            r_note_idx <= r_note_idx + 1'b1;
                        end
                    end else if (w_half_period == '0) begin
                        r_count   <= '0;
                        r_speaker <= 1'b0;
                    end else if (r_count == w_half_period - HP_W'(1)) begin
                        r_count   <= '0;
                        r_speaker <= ~r_speaker;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_count    <= '0;
                    r_speaker  <= 1'b0;
                    r_note_idx <= '0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_count    <= '0;
                    r_speaker  <= 1'b0;
                    r_note_idx <= '0;
                end
            endcase
        end
    end

    assign speaker  = r_speaker;
    assign busy     = (r_state == PLAY);
    assign done     = (r_state == DONE);
    assign note_idx = r_note_idx;

endmodule

// File: tb/tb_beat_tone_player.sv
// -----------------------------------------------------------------------------
// tb_beat_tone_player
// Directed bench for beat_tone_player. The player is built with
// CLK_HZ = 500 kHz so the note half-periods shrink by 100x:
// C5 -> 477, E5 -> 379, G5 -> 318 cycles.
// -----------------------------------------------------------------------------
module tb_beat_tone_player;

    localparam int unsigned HP_C5 = 477;
    localparam int unsigned HP_E5 = 379;
    localparam int unsigned HP_G5 = 318;
    localparam int unsigned LIMIT = 5000;
    // Beat change at a negedge -> sync1, sync2 (tick), then acted on: 3 edges.
    localparam int unsigned BEAT_LAT = 3;

    logic       clk;
    logic       reset;
    logic       beat_in;
    logic       start;
    logic       stop;
    logic       speaker;
    logic       busy;
    logic       done;
    logic [2:0] note_idx;

    int n_checks;
    int n_errors;

    beat_tone_player #(
        .CLK_HZ    (500_000),
        .NUM_NOTES (8),
        .IDX_W     (3),
        .HP_W      (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .beat_in  (beat_in),
        .start    (start),
        .stop     (stop),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles (negedges) until speaker reaches lvl; LIMIT on timeout.
    task automatic wait_speaker(input logic lvl, output int cnt);
        cnt = 0;
        while (speaker !== lvl && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Toggle the beat level and check the step advance and its latency.
    task automatic step_beat(input string tag, input int exp_idx);
        int cnt;
        beat_in = ~beat_in;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (note_idx !== 3'(exp_idx) && cnt < 20);
        check_val({tag, "_lat"}, cnt, BEAT_LAT);
        check_val({tag, "_idx"}, {29'd0, note_idx}, exp_idx);
        check_val({tag, "_spk"}, {31'd0, speaker}, 0);
        check_val({tag, "_busy"}, {31'd0, busy}, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  seen;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        beat_in  = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;

        // Reset with beat_in high; post-reset sync edge must not start anything.
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_spk", {31'd0, speaker}, 0);
        check_val("rst_busy_after", {31'd0, busy}, 0);
        check_val("rst_done", {31'd0, done}, 0);
        check_val("rst_idx", {29'd0, note_idx}, 0);

        // Normal play.
        pulse_start();
        check_val("start_busy", {31'd0, busy}, 1);
        check_val("start_idx", {29'd0, note_idx}, 0);
        wait_speaker(1'b1, cnt);
        check_val("s0_rise", cnt, HP_C5);
        wait_speaker(1'b0, cnt);
        check_val("s0_fall", cnt, HP_C5);
        wait_speaker(1'b1, cnt);
        check_val("s0_rise2", cnt, HP_C5);

        step_beat("b1", 1);
        wait_speaker(1'b1, cnt);
        check_val("s1_rise", cnt, HP_E5);
        step_beat("b2", 2);
        wait_speaker(1'b1, cnt);
        check_val("s2_rise", cnt, HP_G5);

        // Rest step: silent for a long stretch.
        step_beat("b3", 3);
        seen = 1'b0;
        repeat (1500) begin
            @(negedge clk);
            if (speaker) seen = 1'b1;
        end
        check_val("rest_silent", {31'd0, seen}, 0);

        step_beat("b4", 4);
        wait_speaker(1'b1, cnt);
        check_val("s4_rise", cnt, HP_G5);
        // Start while busy is ignored.
        pulse_start();
        check_val("busy_start_idx", {29'd0, note_idx}, 4);
        check_val("busy_start_busy", {31'd0, busy}, 1);

        step_beat("b5", 5);
        step_beat("b6", 6);
        step_beat("b7", 7);

        // Final beat: done pulse of exactly one cycle.
        beat_in = ~beat_in;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (done !== 1'b1 && cnt < 20);
        check_val("done_lat", cnt, BEAT_LAT);
        check_val("done_busy", {31'd0, busy}, 0);
        check_val("done_spk", {31'd0, speaker}, 0);
        @(negedge clk);
        check_val("done_width", {31'd0, done}, 0);
        check_val("end_busy", {31'd0, busy}, 0);
        check_val("end_idx", {29'd0, note_idx}, 0);

        // Stop mid-note during step 2 with speaker high.
        repeat (5) @(negedge clk);
        pulse_start();
        step_beat("sb1", 1);
        step_beat("sb2", 2);
        wait_speaker(1'b1, cnt);
        check_val("stop_pre_rise", cnt, HP_G5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("stop_spk", {31'd0, speaker}, 0);
        check_val("stop_busy", {31'd0, busy}, 0);
        check_val("stop_idx", {29'd0, note_idx}, 0);
        seen = done;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("stop_no_done", {31'd0, seen}, 0);

        // start together with stop in IDLE stays idle.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_val("startstop_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        check_val("startstop_busy2", {31'd0, busy}, 0);

        // Asynchronous reset mid-playback at step 5.
        pulse_start();
        step_beat("rb1", 1);
        step_beat("rb2", 2);
        step_beat("rb3", 3);
        step_beat("rb4", 4);
        step_beat("rb5", 5);
        wait_speaker(1'b1, cnt);
        check_val("rb5_rise", cnt, HP_E5);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_spk", {31'd0, speaker}, 0);
        check_val("arst_busy", {31'd0, busy}, 0);
        check_val("arst_done", {31'd0, done}, 0);
        check_val("arst_idx", {29'd0, note_idx}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_val("arst_still_idle", {31'd0, busy}, 0);

        // Fresh start plays from step 0.
        pulse_start();
        check_val("restart_busy", {31'd0, busy}, 1);
        check_val("restart_idx", {29'd0, note_idx}, 0);
        wait_speaker(1'b1, cnt);
        check_val("restart_rise", cnt, HP_C5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
